// File: rtl/jk_bank_arbiter.sv
// Two-requester arbiter driving a shared W-bit JK flip-flop bank, with shadow state and settle gap.
// Define JKARB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin.
module jk_bank_arbiter #(
    parameter int W          = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_a,
    input  logic [1:0]   cmd_a,
    input  logic [W-1:0] mask_a,
    input  logic         req_b,
    input  logic [1:0]   cmd_b,
    input  logic [W-1:0] mask_b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic [W-1:0] j_out,
    output logic [W-1:0] k_out,
    output logic [W-1:0] q_shadow,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t       state;
    logic [3:0]   settle_cnt;
    logic         pick_b;
    logic [1:0]   sel_cmd;
    logic [W-1:0] sel_mask;
    logic [W-1:0] j_d;
    logic [W-1:0] k_d;

`ifdef JKARB_FIXED_PRIO_EN
    always_comb begin
        pick_b = req_b & ~req_a;
    end
`else
    // last_winner: 1 means B won last, so A takes the next tie
    logic last_winner;

    always_comb begin
        pick_b = req_b & (~req_a | ~last_winner);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= 1'b1;
        end else if (state == IDLE && (req_a || req_b)) begin
            last_winner <= pick_b;
        end
    end
`endif

    always_comb begin
        sel_cmd  = pick_b ? cmd_b  : cmd_a;
        sel_mask = pick_b ? mask_b : mask_a;
        j_d      = sel_cmd[1] ? sel_mask : '0;
        k_d      = sel_cmd[0] ? sel_mask : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            j_out      <= '0;
            k_out      <= '0;
            q_shadow   <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        state <= DRIVE;
                        busy  <= 1'b1;
                        gnt_a <= ~pick_b;
                        gnt_b <= pick_b;
                        j_out <= j_d;
                        k_out <= k_d;
                    end
                end
                DRIVE: begin
                    gnt_a    <= 1'b0;
                    gnt_b    <= 1'b0;
                    j_out    <= '0;
                    k_out    <= '0;
                    // JK next state: set where J & ~q, keep where ~K & q
                    q_shadow <= (j_out & ~q_shadow) | (~k_out & q_shadow);
                    if (SETTLE_CYC == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= 4'(SETTLE_CYC - 1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
